// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared state encoding and constants for the instruction-fetch stage
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

endpackage

// File: rtl/instr_fetch_perf.sv
// rtl/instr_fetch_perf.sv - delivered-instruction and stall-cycle counters for instr_fetch
module instr_fetch_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        xfer,
  input  logic        stall,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  // free-running event counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (xfer)  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC owner, ROM addressing and decode hand-off; INSTR_FETCH_PERF_CNT_EN adds perf counters
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 14,
  parameter logic [ADDR_W+1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W+1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_inst,
  output logic [ADDR_W+1:0]  out_pc,
  output logic               fault
`ifdef INSTR_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam int PW = ADDR_W + 2;

  state_e        state;
  logic [PW-1:0] pc_q;
  logic          xfer;
  logic          advance;
  logic          misaligned;

  // ROM address tracks the PC register directly; a stall keeps it steady so the ROM re-reads the same word
  assign rom_addr   = pc_q[PW-1:2];
  assign xfer       = out_valid && out_ready;
  assign advance    = (state == ST_FETCH) && (!out_valid || out_ready);
  assign misaligned = |redirect_pc[1:0];

  // fetch FSM: redirect wins over everything except FAULT, which only reset can leave
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc_q      <= RESET_PC;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
      fault     <= 1'b0;
    end else if (state == ST_FAULT) begin
      out_valid <= 1'b0;
    end else if (redirect_valid) begin
      // any word being handed over this cycle is kept by decode; everything after is flushed
      out_valid <= 1'b0;
      if (misaligned) begin
        state <= ST_FAULT;
        fault <= 1'b1;
      end else begin
        pc_q <= redirect_pc;
      end
    end else if (state == ST_FETCH && fetch_en) begin
      if (advance) begin
        out_inst  <= rom_data;
        out_pc    <= pc_q;
        out_valid <= 1'b1;
        pc_q      <= pc_q + PW'(PC_INC);
      end
    end else begin
      // IDLE, or FETCH being stopped: no capture, but a held word can still drain
      if (xfer) out_valid <= 1'b0;
      state <= fetch_en ? ST_FETCH : ST_IDLE;
    end
  end

`ifdef INSTR_FETCH_PERF_CNT_EN
  logic stall;
  assign stall = (state == ST_FETCH) && out_valid && !out_ready;

  instr_fetch_perf u_perf (
    .clk            (clk),
    .rst_n          (rst_n),
    .xfer           (xfer),
    .stall          (stall),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage that sits directly upstream of the instruction ROM and downstream-feeds the decoder. It owns the program counter, drives the ROM word address, captures the returned 32-bit word together with its PC into an output register, and hands it to decode over a valid/ready handshake. It also supports PC redirects (branch/jump) with flush, start/stop control, and a sticky misalignment fault.

## Interface
Parameters:
- ADDR_W, 14, ROM word-address width; PC width is ADDR_W+2 (byte address).
- RESET_PC, 16'h0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  level; 1 = fetching permitted.
- redirect_valid  in  1  single-cycle request to load a new PC.
- redirect_pc  in  ADDR_W+2  target byte address.
- rom_addr  out  ADDR_W  word address to ROM read port; equals pc_q[ADDR_W+1:2].
- rom_data  in  32  ROM read data; the ROM samples rom_addr on negedge clk and registers the word.
- out_valid  out  1  out_inst/out_pc hold a valid instruction.
- out_ready  in  1  decoder accepts this cycle.
- out_inst  out  32  fetched instruction.
- out_pc  out  ADDR_W+2  byte address of out_inst.
- fault  out  1  sticky misaligned-redirect flag.

## Operation
- State machine: IDLE, FETCH, FAULT. Reset -> IDLE.
- Reset values: pc_q=RESET_PC, out_valid=0, out_inst=0, out_pc=0, fault=0, state=IDLE.
- rom_addr is always pc_q[ADDR_W+1:2] (combinational from register).
- advance = (state==FETCH) && (!out_valid || out_ready).
- On advance: out_inst<=rom_data, out_pc<=pc_q, out_valid<=1, pc_q<=pc_q+4.
- FETCH with out_valid && !out_ready: hold pc_q and output register (stall); rom_addr unchanged, so rom_data is re-read identically.
- IDLE: no capture; if out_valid && out_ready, out_valid<=0. fetch_en=1 -> FETCH.
- FETCH: fetch_en=0 -> IDLE at the posedge; that cycle does not advance; an already-held output stays valid until accepted.
- Redirect (priority over every other action, any state except FAULT): pc_q<=redirect_pc, out_valid<=0; state unchanged. If redirect_pc[1:0]!=0: state<=FAULT, fault<=1, pc_q unchanged.
- Redirect in the same cycle as an output transfer: transfer completes (decoder keeps that word), then flush.
- FAULT: out_valid=0, no fetch, no redirect; left only by reset.
- PC arithmetic modulo 2^(ADDR_W+2): max aligned address + 4 wraps to 0, no flag.

## Timing
- ROM latency: address from pc_q set at posedge t, sampled by ROM at negedge in cycle t, data valid at posedge t+1, captured by the advance at posedge t+1.
- Steady-state throughput: 1 instruction/cycle with out_ready=1.
- First out_valid: 1 cycle after entering FETCH (edge IDLE->FETCH at t, out_valid=1 after t+1).
- Redirect at posedge t: out_valid=0 after t; instruction at redirect_pc valid after t+1; redirect penalty 1 bubble.
- rst_n assertion mid-operation clears all state immediately; rst_n must be held across at least one negedge.

## Configuration
- INSTR_FETCH_PERF_CNT_EN defined: adds outputs perf_fetch_cnt[31:0] (increments on each out_valid&&out_ready) and perf_stall_cnt[31:0] (increments each cycle in FETCH with out_valid && !out_ready); both reset to 0, wrap at 2^32.
- Undefined: neither ports nor counters exist; behaviour otherwise identical.

## Structure
- Shared package: state encoding (IDLE=2'd0, FETCH=2'd1, FAULT=2'd2), INSTR_W=32, PC increment constant 4.
- Single flat module; perf counters in a sub-module instr_fetch_perf instantiated only under the macro.

## Test plan
- Reset with RESET_PC=0x0100, fetch_en=1, out_ready=1 -> out_pc 0x0100, 0x0104, 0x0108 on consecutive cycles with matching ROM words; rom_addr 0x40, 0x41, 0x42.
- out_ready held 0 for 3 cycles with out_valid=1 -> out_pc/out_inst frozen, rom_addr frozen; release -> next PC follows with no loss/duplication; perf_stall_cnt=3 when macro defined.
- redirect_pc=0x0200 during steady fetch -> one bubble, next out_pc=0x0200, no stale word delivered.
- redirect_pc=0x0202 -> fault=1, out_valid=0 forever, fetch_en toggling has no effect; rst_n pulse clears fault.
- PC at 0xFFFC (ADDR_W=14) -> next out_pc 0x0000, rom_addr 0.
- fetch_en dropped mid-stream with out_ready=0 -> held word stays valid, accepted later, no further fetch until fetch_en=1.
